// File: rtl/depkt_pkg.sv
// Shared definitions for the DePacketizer flit arbiter: flit field layout,
// tail marker, arbiter state encoding and the tail-detection helper.
package depkt_pkg;

  localparam int          FLIT_W    = 48;
  localparam logic [15:0] TAIL_MARK = 16'hFFFF;
  localparam int          HDR_HI    = 47;
  localparam int          HDR_LO    = 32;
  localparam int          DATA_HI   = 31;
  localparam int          DATA_LO   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic is_tail(input logic [FLIT_W-1:0] flit, input logic [15:0] mark);
    return flit[HDR_HI:HDR_LO] == mark;
  endfunction

endpackage

// File: rtl/depkt_flit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after the
// pointer wins, wrapping around; reusable for any shared NoC port.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    // Offsets 1..NUM_REQ visit every source once, the pointer holder last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/depkt_flit_arbiter.sv
// Wormhole arbiter feeding one DePacketizer flit input from NUM_REQ sources;
// a grant is held for a whole packet and flits leave through an output register.
module depkt_flit_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          FLIT_W        = depkt_pkg::FLIT_W,
  parameter logic [15:0] TAIL_MARK     = depkt_pkg::TAIL_MARK,
  parameter int          MAX_PKT_FLITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]   req_flit,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [FLIT_W-1:0]           flitoutde,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [15:0]                 pkt_count,
  output logic                        err_overlong
);

  import depkt_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_FLITS + 1);

  state_t            r_state;
  logic [IW-1:0]     r_grant_id;
  logic [IW-1:0]     r_rr_ptr;
  logic [FLIT_W-1:0] r_flit;
  logic              r_flit_valid;
  logic [15:0]       r_pkt_count;
  logic              r_err_overlong;
  logic [CW-1:0]     r_flit_cnt;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IW-1:0]      w_arb_idx;
  logic               w_arb_any;
  logic               w_out_free;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic               w_accept;
  logic               w_tail;
  logic               w_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_out_free = !r_flit_valid || flit_ready;
  assign w_sel_flit = req_flit[r_grant_id*FLIT_W +: FLIT_W];
  assign w_accept   = (r_state == LOCKED) && req_valid[r_grant_id] && w_out_free;
  assign w_tail     = is_tail(w_sel_flit, TAIL_MARK);
  assign w_last     = (r_flit_cnt == CW'(MAX_PKT_FLITS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (r_state == LOCKED) && (r_grant_id == IW'(gi)) && w_out_free;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_grant_id     <= '0;
      r_rr_ptr       <= IW'(NUM_REQ - 1);
      r_flit         <= '0;
      r_flit_valid   <= 1'b0;
      r_pkt_count    <= '0;
      r_err_overlong <= 1'b0;
      r_flit_cnt     <= '0;
    end else begin
      r_err_overlong <= 1'b0;

      // The output register drains independently of the arbitration state.
      if (w_accept) begin
        r_flit       <= w_sel_flit;
        r_flit_valid <= 1'b1;
      end else if (r_flit_valid && flit_ready) begin
        r_flit_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_grant_id <= w_arb_idx;
            r_flit_cnt <= '0;
            r_state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept) begin
            r_flit_cnt <= r_flit_cnt + CW'(1);
            if (w_tail || w_last) begin
              r_state        <= IDLE;
              r_rr_ptr       <= r_grant_id;
              r_pkt_count    <= r_pkt_count + 16'd1;
              r_err_overlong <= !w_tail;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flitoutde    = r_flit;
  assign flit_valid   = r_flit_valid;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == LOCKED);
  assign pkt_count    = r_pkt_count;
  assign err_overlong = r_err_overlong;

endmodule

// File: tb/tb_depkt_flit_arbiter.sv
// Randomised bench for depkt_flit_arbiter: sources stream flits from per-source
// buffers and a behavioural model predicts every output cycle by cycle.
module tb_depkt_flit_arbiter;

  localparam int          N    = 4;
  localparam int          W    = 48;
  localparam int          MAXF = 16;
  localparam logic [15:0] TM   = 16'hFFFF;
  localparam int          DEPTH = 64;

  typedef logic [W-1:0] flit_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*W-1:0]    req_flit = '0;
  logic [N-1:0]      req_ready;
  logic [W-1:0]      flitoutde;
  logic              flit_valid;
  logic              flit_ready = 1'b1;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       pkt_count;
  logic              err_overlong;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  // Source buffers
  flit_t src_mem [N][DEPTH];
  int    src_len [N];
  int    src_pos [N];

  // Behavioural model
  bit    m_locked;
  int    m_owner;
  int    m_ptr;
  int    m_cnt;
  bit    m_ov;
  flit_t m_of;
  int    m_pkt;
  bit    m_err;

  depkt_flit_arbiter #(
    .NUM_REQ       (N),
    .FLIT_W        (W),
    .TAIL_MARK     (TM),
    .MAX_PKT_FLITS (MAXF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_flit     (req_flit),
    .req_ready    (req_ready),
    .flitoutde    (flitoutde),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .err_overlong (err_overlong)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = N - 1;
    m_cnt    = 0;
    m_ov     = 1'b0;
    m_of     = '0;
    m_pkt    = 0;
    m_err    = 1'b0;
  endtask

  task automatic add_flit(input int s, input flit_t f);
    if (src_pos[s] == src_len[s]) begin
      src_pos[s] = 0;
      src_len[s] = 0;
    end
    src_mem[s][src_len[s]] = f;
    src_len[s]++;
  endtask

  // len flits; the last one carries TM when tail is set, all others never do.
  task automatic add_pkt(input int s, input int len, input bit tail);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f[47:32] = 16'($urandom_range(16'hFFFE, 0));
      f[31:16] = 16'($urandom);
      f[15:0]  = 16'($urandom);
      if (tail && i == len - 1) f[47:32] = TM;
      add_flit(s, f);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_flit_valid", flit_valid, 0);
    check_eq("rst_flitoutde", flitoutde, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_err", err_overlong, 0);
    check_eq("rst_req_ready", req_ready, 0);
    model_reset();
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input int pv, input int pr);
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    bit           out_free;
    bit           acc;
    bit           found;
    flit_t        f;
    int           c;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      v[i] = (src_pos[i] < src_len[i]) && ($urandom_range(99) < pv);
      req_flit[i*W +: W] = (src_pos[i] < src_len[i]) ? src_mem[i][src_pos[i]] : flit_t'($urandom);
    end
    req_valid  = v;
    flit_ready = ($urandom_range(99) < pr);
    #1;
    out_free = !m_ov || flit_ready;
    exp_rdy  = '0;
    if (m_locked && out_free) exp_rdy = N'(1 << m_owner);
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("flit_valid", flit_valid, m_ov);
    if (m_ov) check_eq("flitoutde", flitoutde, m_of);
    check_eq("busy", busy, m_locked);
    check_eq("grant_id", grant_id, m_owner);
    check_eq("pkt_count", pkt_count, m_pkt);
    check_eq("err_overlong", err_overlong, m_err);
    if (err_overlong) err_seen++;

    acc   = m_locked && v[m_owner[1:0]] && out_free;
    m_err = 1'b0;
    f     = '0;
    if (acc) begin
      f = src_mem[m_owner][src_pos[m_owner]];
      src_pos[m_owner]++;
      m_of = f;
      m_ov = 1'b1;
    end else if (m_ov && flit_ready) begin
      m_ov = 1'b0;
    end

    if (!m_locked) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && v[c]) begin
          found    = 1'b1;
          m_owner  = c;
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end
    end else if (acc) begin
      m_cnt++;
      if (f[47:32] == TM || m_cnt == MAXF) begin
        m_locked = 1'b0;
        m_ptr    = m_owner;
        m_pkt    = (m_pkt + 1) & 16'hFFFF;
        m_err    = (f[47:32] != TM);
      end
    end
  endtask

  initial begin
    int err_before;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    model_reset();
    apply_reset();

    // Single two-flit packet from source 0
    add_flit(0, 48'h0001_AAAA_0000);
    add_flit(0, 48'hFFFF_BBBB_0000);
    for (int i = 0; i < 6; i++) step(100, 100);
    check_eq("pkt1_count", pkt_count, 1);
    check_eq("pkt1_last_flit", flitoutde, 48'hFFFF_BBBB_0000);

    // All sources busy with two-flit packets
    for (int s = 0; s < N; s++) begin
      add_pkt(s, 2, 1'b1);
      add_pkt(s, 2, 1'b1);
    end
    for (int i = 0; i < 30; i++) step(100, 100);
    check_eq("rr_pkt_count", pkt_count, 9);

    // Overlong packet forces a release after MAXF flits
    err_before = err_seen;
    add_pkt(0, MAXF, 1'b0);
    add_pkt(0, 2, 1'b1);
    for (int i = 0; i < 26; i++) step(100, 100);
    check_eq("overlong_pulses", err_seen - err_before, 1);
    check_eq("overlong_pkt_count", pkt_count, 11);

    // Random traffic with backpressure and a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      for (int s = 0; s < N; s++)
        if (src_pos[s] == src_len[s] && $urandom_range(99) < 30)
          add_pkt(s, int'($urandom_range(20, 1)), 1'b1);
      if (i == 1500) apply_reset();
      step(75, 70);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/depkt_flit_arbiter.md
Name: depkt_flit_arbiter

Overview:
Wormhole arbiter that shares one DePacketizer flit input (flitoutde) among NUM_REQ flit sources. It grants one source round-robin and locks the grant for a whole packet, releasing it on the tail flit (header field [47:32] == TAIL_MARK). Flits go out through a registered output stage. A per-packet flit counter forces release of packets that never send a tail.

Parameters:
NUM_REQ, 4, number of flit sources
FLIT_W, 48, flit width; header [47:32], data [31:16], low field [15:0] passed through unchanged
TAIL_MARK, 16'hFFFF, header value that marks the tail flit
MAX_PKT_FLITS, 16, most flits allowed per packet before forced release (>=1)

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  source i presents a flit
req_flit  in  NUM_REQ*FLIT_W  flit of source i at bits [i*FLIT_W +: FLIT_W]
req_ready  out  NUM_REQ  source i flit accepted this cycle when req_valid[i] is also high
flitoutde  out  FLIT_W  registered flit to the DePacketizer
flit_valid  out  1  flitoutde holds a valid flit
flit_ready  in  1  downstream takes the flit; tie to 1 for the DePacketizer
grant_id  out  $clog2(NUM_REQ)  current or most recent granted source
busy  out  1  high in LOCKED
pkt_count  out  16  number of packets completed (tail or forced); wraps
err_overlong  out  1  one-cycle pulse on a forced release

Behaviour:
- Reset (async, active-high):
  - state=IDLE; flitoutde=0; flit_valid=0; grant_id=0; busy=0; pkt_count=0; err_overlong=0; flit counter=0.
  - rr pointer=NUM_REQ-1, so source 0 wins first.
  - A reset mid-packet drops the packet; nothing is replayed.
- States: IDLE, LOCKED.
- IDLE:
  - req_ready is all 0.
  - If any req_valid is high, pick the first valid source after the rr pointer, wrapping.
  - At the next edge: grant_id=winner, state=LOCKED, flit counter=0.
  - If no req_valid is high, stay in IDLE.
- LOCKED:
  - Output stage can take a flit: out_free = !flit_valid || flit_ready.
  - req_ready[grant_id] = out_free; all other req_ready bits are 0. This is combinational.
  - Accept = req_valid[grant_id] && req_ready[grant_id]. On accept: flitoutde<=flit, flit_valid<=1, flit counter +1.
  - Output drained with no accept (flit_valid && flit_ready): flit_valid<=0.
  - Tail accept (header == TAIL_MARK): state->IDLE, rr pointer<=grant_id, pkt_count+1.
  - Forced release: a non-tail accept when the counter is MAX_PKT_FLITS-1. The flit is still forwarded. Then state->IDLE, rr pointer<=grant_id, pkt_count+1, err_overlong pulses for 1 cycle.
  - If the granted source drops req_valid mid-packet, stay LOCKED. Nothing is sent and the counter does not advance; only accepted flits count.
- Single-flit packet: a flit whose header is TAIL_MARK is head and tail at once, so the packet ends immediately.
- Latency:
  - req_valid seen in IDLE at edge N; grant at N; first flit accepted at N+1; flit_valid high after N+1.
  - Each packet costs one IDLE bubble cycle, used for arbitration.
  - With flit_ready=1, throughput is 1 flit/cycle inside a packet.
- Flits are never interleaved between sources. The output register holds its flit until flit_ready.
- Counter width: $clog2(MAX_PKT_FLITS+1). pkt_count wraps from 16'hFFFF to 0.

Decomposition:
- Package depkt_pkg holds:
  - FLIT_W, TAIL_MARK, HDR_HI=47, HDR_LO=32, DATA_HI=31, DATA_LO=16;
  - state enum {IDLE, LOCKED};
  - an is_tail(flit) function.
- One sub-module, rr_arbiter (parameter NUM_REQ): combinational. Inputs are the request vector and the pointer; outputs are a one-hot grant, the encoded index, and any_req. The same module can be reused later for other shared NoC ports.

Test Plan:
- Reset then req_valid=4'b0001, source 0 sends head 48'h0001_AAAA_0000, then tail 48'hFFFF_BBBB_0000 -> flitoutde shows both in order; pkt_count=1; grant_id=0; busy falls after the tail.
- req_valid=4'b1111 held, each source sends 2-flit packets -> grant order 0,1,2,3,0; one bubble between packets; no flits interleaved.
- Source 2 sends a packet; source 1 raises req_valid mid-packet -> req_ready[1] stays 0 until source 2's tail; then source 1 is granted.
- Source 0 sends 16 flits with header 16'h0001 -> 16th flit forwarded; err_overlong pulses once; pkt_count+1; state returns to IDLE.
- flit_ready=0 for 3 cycles mid-packet -> flitoutde held stable; req_ready low; no flit lost or duplicated.
- reset asserted mid-packet -> outputs drop at once to reset values; next grant goes to source 0.
